// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Define MDU_MACC_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7..A).
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic dec_mul, dec_div, dec_mthi, dec_mtlo;

    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        case (MDUOp)
            OP_MULT, OP_MULTU: dec_mul  = 1'b1;
            OP_DIV, OP_DIVU:   dec_div  = 1'b1;
            OP_MTHI:           dec_mthi = 1'b1;
            OP_MTLO:           dec_mtlo = 1'b1;
`ifdef MDU_MACC_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: dec_mul  = 1'b1;
`endif
            default: ;
        endcase
    end

    // One shared multiplier: signed ops sign-extend, unsigned ops zero-extend.
    logic                 sx;
    logic [2*WIDTH-1:0]   mx, my, prod, hilo;

    assign sx   = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign mx   = {{WIDTH{sx & a_q[WIDTH-1]}}, a_q};
    assign my   = {{WIDTH{sx & b_q[WIDTH-1]}}, b_q};
    assign prod = mx * my;
    assign hilo = {HI, LO};

    // Divide on magnitudes, then restore signs (remainder follows dividend).
    logic             sd, na, nb;
    logic [WIDTH-1:0] ma, mb, dv, uq, ur, quo, rem;

    assign sd  = (op_q == OP_DIV);
    assign na  = sd & a_q[WIDTH-1];
    assign nb  = sd & b_q[WIDTH-1];
    assign ma  = na ? -a_q : a_q;
    assign mb  = nb ? -b_q : b_q;
    assign dv  = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mb;
    assign uq  = ma / dv;
    assign ur  = ma % dv;
    assign quo = (na ^ nb) ? -uq : uq;
    assign rem = na ? -ur : ur;

    logic [2*WIDTH-1:0] res;

    always_comb begin
        res = hilo;
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU: begin
                if (b_q != '0) res = {rem, quo};
            end
`ifdef MDU_MACC_EN
            OP_MADD, OP_MADDU: res = hilo + prod;
            OP_MSUB, OP_MSUBU: res = hilo - prod;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        unique case (1'b1)
                            dec_mul, dec_div: begin
                                state <= RUN;
                                Busy  <= 1'b1;
                                cnt   <= dec_mul ? MC : DC;
                                op_q  <= MDUOp;
                                a_q   <= SrcA;
                                b_q   <= SrcB;
                            end
                            dec_mthi: HI <= SrcA;
                            dec_mtlo: LO <= SrcA;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        {HI, LO} <= res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and random checks of mdu_unit against an
// arithmetic reference model of HI/LO and Busy latency.
module tb_mdu_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [3:0]   MDUOp;
    logic [W-1:0] SrcA, SrcB;
    logic         Busy;
    logic [W-1:0] HI, LO;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: new HI/LO from plain arithmetic; returns expected Busy cycles.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
        longint q, r, sp;
        logic [63:0] up;
        cyc = 0;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        case (op)
            4'd1: begin cyc = MC; {mhi, mlo} = sp; end
            4'd2: begin cyc = MC; {mhi, mlo} = up; end
            4'd3: begin
                cyc = DC;
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    mlo = q[31:0];
                    mhi = r[31:0];
                end
            end
            4'd4: begin
                cyc = DC;
                if (b != 0) begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
            4'd5: mhi = a;
            4'd6: mlo = a;
`ifdef MDU_MACC_EN
            4'd7:  begin cyc = MC; {mhi, mlo} = {mhi, mlo} + sp; end
            4'd8:  begin cyc = MC; {mhi, mlo} = {mhi, mlo} + up; end
            4'd9:  begin cyc = MC; {mhi, mlo} = {mhi, mlo} - sp; end
            4'd10: begin cyc = MC; {mhi, mlo} = {mhi, mlo} - up; end
`endif
            default: ;
        endcase
    endtask

    // Caller is at a negedge; Start is sampled at the next posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n, cyc;
        issue(op, a, b);
        wait_idle(n);
        model(op, a, b, cyc);
        check({tag, ".cyc"}, n, cyc);
        check({tag, ".hi"}, HI, mhi);
        check({tag, ".lo"}, LO, mlo);
    endtask

    initial begin
        int n, cyc;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1;
        Start = 1'b0;
        MDUOp = '0;
        SrcA  = '0;
        SrcB  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst.busy", Busy, 0);
        check("rst.hi", HI, 0);
        check("rst.lo", LO, 0);

        run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5);
        check("mult.hi.k", HI, 32'hFFFFFFFF);
        check("mult.lo.k", LO, 32'hFFFFFFF1);
        run_op("multu", 4'd2, 32'hFFFFFFFD, 32'd5);
        check("multu.hi.k", HI, 32'h00000004);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2);
        check("div.lo.k", LO, 32'hFFFFFFFD);
        check("div.hi.k", HI, 32'hFFFFFFFF);
        run_op("divu", 4'd4, 32'd7, 32'd2);
        check("divu.lo.k", LO, 32'd3);
        run_op("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF);
        check("divmin.lo.k", LO, 32'h80000000);
        check("divmin.hi.k", HI, 32'h0);
        run_op("mthi", 4'd5, 32'h1234, 32'd0);
        run_op("mtlo", 4'd6, 32'h5678, 32'd0);
        run_op("divu0", 4'd4, 32'd99, 32'd0);
        check("divu0.hi.k", HI, 32'h1234);
        check("divu0.lo.k", LO, 32'h5678);
        run_op("div0", 4'd3, 32'h80000001, 32'd0);
        run_op("nop", 4'd0, 32'd1, 32'd1);
        run_op("undef", 4'd15, 32'd1, 32'd1);

`ifdef MDU_MACC_EN
        run_op("m.mthi", 4'd5, 32'h0, 32'd0);
        run_op("m.mtlo", 4'd6, 32'hFFFFFFFF, 32'd0);
        run_op("maddu", 4'd8, 32'd1, 32'd1);
        check("maddu.hi.k", HI, 32'd1);
        check("maddu.lo.k", LO, 32'd0);
        run_op("msub", 4'd9, 32'd1, 32'd1);
        check("msub.hi.k", HI, 32'd0);
        check("msub.lo.k", LO, 32'hFFFFFFFF);
        run_op("madd", 4'd7, 32'hFFFFFFF0, 32'd3);
        run_op("msubu", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
        run_op("maddu.off", 4'd8, 32'd1, 32'd1);
        run_op("msub.off", 4'd9, 32'd1, 32'd1);
`endif

        // Start while busy is ignored; input changes after capture are ignored.
        issue(4'd1, 32'hFFFF0007, 32'd9);
        check("ign.busy1", Busy, 1);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = 4'd4;
        SrcA  = 32'd9;
        SrcB  = 32'd2;
        @(negedge clk);
        Start = 1'b0;
        SrcA  = 32'h55;
        wait_idle(n);
        model(4'd1, 32'hFFFF0007, 32'd9, cyc);
        check("ign.cyc", n + 2, cyc);
        check("ign.hi", HI, mhi);
        check("ign.lo", LO, mlo);
        @(negedge clk);
        check("ign.idle", Busy, 0);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 12));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d.op%0d", i, op), op, a, b);
        end

        // Reset mid-divide aborts the op with no later commit.
        run_op("r.mthi", 4'd5, 32'hAAAA, 32'd0);
        run_op("r.mtlo", 4'd6, 32'hAAAA, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2.busy", Busy, 0);
        check("rst2.hi", HI, 0);
        check("rst2.lo", LO, 0);
        repeat (DC + 3) @(negedge clk);
        check("rst2.late.busy", Busy, 0);
        check("rst2.late.hi", HI, 0);
        check("rst2.late.lo", LO, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers, the successor to the single-cycle combinational ALU in the SingleCPU datapath.
- Sits beside the ALU in the EX stage of the pipelined CPU.
- Accepts one operation per Start pulse, asserts Busy for a fixed latency, then commits the result to HI/LO.
- The hazard unit stalls any MDU instruction in EX while Start or Busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, Busy cycles for multiply-class ops (>=1)
DIV_CYCLES, 10, Busy cycles for divide-class ops (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request; qualifies MDUOp/SrcA/SrcB
MDUOp  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, A MSUBU, others NOP
SrcA  input  WIDTH  operand A (rs)
SrcB  input  WIDTH  operand B (rt)
Busy  output  1  registered; high while an op is in flight
HI  output  WIDTH  HI register (remainder / upper product)
LO  output  WIDTH  LO register (quotient / lower product)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. All state changes occur on rising clk.
- Reset values: Busy=0, HI=0, LO=0, counter=0, state IDLE. Reset overrides every other input, including mid-operation: the op is aborted and no commit occurs.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; a down-counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - In RUN, each edge decrements the counter. On the edge where counter==1, the result commits to HI/LO and the state returns to IDLE.
- Latency:
  - Start sampled at edge E0 → Busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO visible from the same cycle Busy falls.
  - A new Start is accepted in that same cycle.
- Operand capture: SrcA, SrcB and the op are latched at E0. Later changes to the inputs have no effect.
- Start while Busy=1: ignored entirely (no state change). The pipeline must not issue it.
- Start with NOP or an undefined op: no effect, Busy stays 0.
- MTHI/MTLO with Start in IDLE: HI (resp. LO) <= SrcA at E0. Single cycle, Busy never asserts.
- MULT: {HI,LO} <= signed(SrcA) * signed(SrcB), full 2*WIDTH product.
- MULTU: {HI,LO} <= unsigned(SrcA) * unsigned(SrcB), full 2*WIDTH product.
- DIV: LO <= quotient truncated toward zero; HI <= remainder with the sign of the dividend.
- DIV special case: SrcA = most-negative and SrcB = -1 gives LO = most-negative, HI = 0, with no trap.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (SrcB==0, DIV or DIVU): still runs DIV_CYCLES with Busy=1; HI and LO remain unchanged at commit.
- HI/LO hold their values between commits. They are not modified during RUN; old values stay readable until the commit edge.
- Result computation may be combinational on the latched operands; only the commit timing is specified.

Optional Feature:
- Macro: MDU_MACC_EN.
- Defined: ops 7..A are multiply-class, MULT_CYCLES latency.
  - MADD: {HI,LO} <= {HI,LO} + signed product.
  - MADDU: {HI,LO} <= {HI,LO} + unsigned product.
  - MSUB: {HI,LO} <= {HI,LO} − signed product.
  - MSUBU: {HI,LO} <= {HI,LO} − unsigned product.
  - All modulo 2^(2*WIDTH). The {HI,LO} used is the value at commit time.
- Undefined: ops 7..A decode as NOP; Busy stays 0 and HI/LO are unchanged.

Test Plan:
- Reset, then MULT SrcA=FFFFFFFD (−3), SrcB=5 → Busy high 5 cycles; then HI=FFFFFFFF, LO=FFFFFFF1. MULTU with the same operands → HI=00000004, LO=FFFFFFF1.
- DIV SrcA=FFFFFFF9 (−7), SrcB=2 → Busy 10 cycles; LO=FFFFFFFD, HI=FFFFFFFF. DIVU SrcA=7, SrcB=2 → LO=3, HI=1. DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- MTHI 1234 then MTLO 5678 → Busy never asserts; HI=1234, LO=5678. Then DIVU x/0 → Busy 10 cycles, HI=1234, LO=5678 unchanged.
- MULT started; second Start (DIVU 9/2) in cycle 2 of Busy → ignored. Final HI/LO match the MULT only, and Busy falls after 5 cycles. Changing SrcA during Busy has no effect.
- reset asserted in cycle 3 of a DIV after HI=LO=AAAA → next cycle Busy=0, HI=LO=0, and no later commit.
- With MDU_MACC_EN defined: MTHI 0, MTLO FFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Then MSUB 1×1 → HI=0, LO=FFFFFFFF. Without the macro: MADDU → no Busy, HI/LO unchanged.
